radix4_residual_iter: RTL and testbench

//  Sequential residual-update stage of the radix-4 online datapath. Holds the signed-digit residual,

---
 rtl/radix4_residual_iter.sv | 150 +++++++++++++++
 tb/tb_radix4_residual_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/radix4_residual_iter.sv
// Sequential residual-update stage of the radix-4 online datapath with online delay and handshakes.
// Define RESID_OVF_CHECK_EN to enable the sticky ovf check; otherwise ovf is tied to 0.

module radix4_residual_iter #(
    parameter int unsigned no_of_digits = 4,
    parameter int unsigned radix_bits   = 3,
    parameter int unsigned radix        = 4,
    parameter int unsigned delta        = 2,
    localparam int unsigned ND          = no_of_digits + delta + 1,
    localparam int unsigned WW          = radix_bits * ND
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [radix_bits-1:0] x_digit,
    output logic [WW-1:0]         w_to_mod,
    input  logic [WW-1:0]         w_from_mod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [radix_bits-1:0] z_digit,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned SW = $clog2(ND);
    localparam logic signed [radix_bits-1:0] DigMax = radix_bits'(radix - 1);
    localparam logic signed [radix_bits-1:0] DigMin = -DigMax;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StFlush, StDone} state_e;

    state_e                        state;
    logic [WW-1:0]                 w;
    logic [SW-1:0]                 step;
    logic                          can_out;
    logic                          fire;
    logic signed [radix_bits-1:0]  m_dig;
    logic signed [radix_bits-1:0]  z_dig;
    logic signed [radix_bits-1:0]  r_dig;
    logic [radix_bits-1:0]         x_ins;
    logic [WW-1:0]                 w_next;
    logic                          unused_top;

    assign w_to_mod   = w;
    assign busy       = (state != StIdle);
    assign can_out    = !out_valid || out_ready;
    assign in_ready   = (state == StLoad) || ((state == StRun) && can_out);
    // The top digit only matters to the overflow check.
    assign unused_top = ^w_from_mod[WW-1 -: radix_bits];

    always_comb begin
        fire = 1'b0;
        case (state)
            StLoad:  fire = in_valid;
            StRun:   fire = in_valid && can_out;
            StFlush: fire = can_out;
            default: fire = 1'b0;
        endcase
    end

    // Digit select, clamp and shift; fields are independent so no carries cross digits.
    always_comb begin
        m_dig = w_from_mod[(ND-2)*radix_bits +: radix_bits];
        if (m_dig > DigMax) begin
            z_dig = DigMax;
        end else if (m_dig < DigMin) begin
            z_dig = DigMin;
        end else begin
            z_dig = m_dig;
        end
        r_dig  = m_dig - z_dig;
        x_ins  = (state == StFlush) ? '0 : x_digit;
        w_next = {r_dig, w_from_mod[(ND-2)*radix_bits-1:0], x_ins};
    end

`ifdef RESID_OVF_CHECK_EN
    logic ovf_hit;
    assign ovf_hit = (w_from_mod[WW-1 -: radix_bits] != '0) || (m_dig < DigMin);
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            w         <= '0;
            step      <= '0;
            z_digit   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef RESID_OVF_CHECK_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (fire && ((state == StRun) || (state == StFlush))) begin
                z_digit   <= z_dig;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (fire) begin
                w    <= w_next;
                step <= step + SW'(1);
`ifdef RESID_OVF_CHECK_EN
                if (ovf_hit) begin
                    ovf <= 1'b1;
                end
`endif
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StLoad;
                        w     <= '0;
                        step  <= '0;
`ifdef RESID_OVF_CHECK_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (fire && (step == SW'(delta - 1))) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (fire && (step == SW'(no_of_digits - 1))) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    if (fire && (step == SW'(no_of_digits + delta - 1))) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_residual_iter.sv
// Randomized bench for radix4_residual_iter against a digit-array reference model.
// Expected ovf follows RESID_OVF_CHECK_EN, matching the build of the design.

module tb_radix4_residual_iter;

    localparam int NOD = 4;
    localparam int RB  = 3;
    localparam int DLT = 2;
    localparam int ND  = NOD + DLT + 1;
    localparam int WW  = RB * ND;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [RB-1:0] x_digit;
    logic [WW-1:0] w_to_mod;
    logic [WW-1:0] w_from_mod;
    logic          out_valid;
    logic          out_ready;
    logic [RB-1:0] z_digit;
    logic          busy;
    logic          done;
    logic          ovf;

    always #5 clk = ~clk;

    radix4_residual_iter #(
        .no_of_digits(NOD),
        .radix_bits  (RB),
        .radix       (4),
        .delta       (DLT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_digit   (x_digit),
        .w_to_mod  (w_to_mod),
        .w_from_mod(w_from_mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_digit   (z_digit),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: residual as signed integer digits, steps counted 0..ND-1.
    int rd[ND];
    int ms;
    bit mact, mov, mdone, movf;
    int mz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rx();
        return int'($urandom_range(6)) - 3;
    endfunction

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // mode: 0 identity, 1 random digit edits, 2 force digit ND-2 to -4, 3 force digit ND-1 to +1,
    // 4 pick one of those each cycle.
    task automatic cyc(input bit st, input bit iv, input int x, input bit ordy, input int mode,
                       input bit r);
        int f[ND];
        int nd[ND];
        int md, m, z;
        bit can, pop, fire, old_act;
        logic [WW-1:0] wexp, wfm;
        logic [RB-1:0] ez;
        md = (mode == 4) ? int'($urandom_range(3)) : mode;
        for (int k = 0; k < ND; k++) begin
            f[k] = rd[k];
            if (md == 1 && $urandom_range(3) == 0) f[k] = int'($urandom_range(7)) - 4;
        end
        if (md == 2) f[ND-2] = -4;
        if (md == 3) f[ND-1] = 1;
        for (int k = 0; k < ND; k++) begin
            wexp[k*RB +: RB] = RB'(rd[k]);
            wfm[k*RB +: RB]  = RB'(f[k]);
        end
        rst        = r;
        start      = st;
        in_valid   = iv;
        x_digit    = RB'(x);
        out_ready  = ordy;
        w_from_mod = wfm;
        #1;
        ez = RB'(mz);
        check("in_ready", 32'(in_ready),
              32'(mact && (ms < DLT || (ms < NOD && (!mov || ordy)))));
        check("out_valid", 32'(out_valid), 32'(mov));
        check("z_digit", 32'(z_digit), 32'(ez));
        check("w_to_mod", 32'(w_to_mod), 32'(wexp));
        check("busy", 32'(busy), 32'(mact));
        check("done", 32'(done), 32'(mdone));
        check("ovf", 32'(ovf), 32'(movf));
        if (r) begin
            for (int k = 0; k < ND; k++) rd[k] = 0;
            ms = 0; mact = 0; mov = 0; mdone = 0; movf = 0; mz = 0;
        end else begin
            can  = !mov || ordy;
            pop  = mov && ordy;
            fire = mact && ((ms < DLT && iv) || (ms >= DLT && ms < NOD && iv && can) ||
                            (ms >= NOD && ms < ND - 1 && can));
            m = f[ND-2];
            z = (m < -3) ? -3 : ((m > 3) ? 3 : m);
            old_act = mact;
            mdone = 0;
            if (fire && ms >= DLT) begin
                mz  = z;
                mov = 1;
            end else if (pop) begin
                mov = 0;
            end
            if (mact && ms == ND - 1 && pop) begin
                mdone = 1;
                mact  = 0;
            end
            if (fire) begin
                for (int k = 1; k < ND; k++) nd[k] = f[k-1];
                nd[ND-1] = m - z;
                nd[0]    = (ms >= NOD) ? 0 : x;
                for (int k = 0; k < ND; k++) rd[k] = nd[k];
                ms++;
`ifdef RESID_OVF_CHECK_EN
                if (f[ND-1] != 0 || m == -4) movf = 1;
`endif
            end
            if (!old_act && st) begin
                mact = 1;
                ms   = 0;
                movf = 0;
                for (int k = 0; k < ND; k++) rd[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One operation; with hold_start the start line stays high throughout and the
    // next operation is launched on the cycle after done.
    task automatic op(input int mode, input int pv, input int pr, input bit hold_start,
                      input int xfix);
        cyc(1'b1, 1'b0, 0, 1'b1, mode, 1'b0);
        for (int c = 0; c < 400 && mact; c++)
            cyc(hold_start, rnd(pv), (xfix < -3) ? rx() : xfix, rnd(pr), mode, 1'b0);
        if (hold_start) begin
            cyc(1'b1, 1'b0, 0, 1'b1, mode, 1'b0);
            for (int c = 0; c < 400 && mact; c++) cyc(1'b0, rnd(pv), rx(), rnd(pr), mode, 1'b0);
        end
        cyc(1'b0, 1'b0, 0, 1'b1, mode, 1'b0);
    endtask

    task automatic op_stall();
        cyc(1'b1, 1'b0, 0, 1'b1, 1, 1'b0);
        for (int c = 0; c < 50 && mact && !mov; c++) cyc(1'b0, 1'b1, rx(), 1'b1, 1, 1'b0);
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, rx(), 1'b0, 1, 1'b0);
        for (int c = 0; c < 50 && mact; c++) cyc(1'b0, 1'b1, rx(), 1'b1, 1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; x_digit = '0; out_ready = 1'b0;
        w_from_mod = '0;
        for (int k = 0; k < ND; k++) rd[k] = 0;
        ms = 0; mact = 0; mov = 0; mdone = 0; movf = 0; mz = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        op(0, 100, 100, 1'b0, 1);
        op_stall();
        op(2, 100, 100, 1'b0, -9);
        op(3, 80, 70, 1'b0, -9);
        op(0, 100, 100, 1'b1, -9);
        // Reset in the middle of an operation, then a clean run.
        cyc(1'b1, 1'b0, 0, 1'b1, 1, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, rx(), 1'b1, 1, 1'b0);
        cyc(1'b0, 1'b1, rx(), 1'b1, 1, 1'b1);
        cyc(1'b0, 1'b1, rx(), 1'b1, 1, 1'b1);
        op(1, 90, 90, 1'b0, -9);
        for (int i = 0; i < 40; i++) op(4, 70, 60, rnd(30), -9);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
